ram_access_arbiter: RTL and testbench
=====================================

// Module: ram_access_arbiter
// PURPOSE
//  Shares the write port of the simple dual-port RAM (sync write, async read) between two
//  write requesters using round-robin arbitration with valid/ready handshakes.
//  Also sequences one read requester: registers RAM read data into a one-cycle response.
//  Sits between producer blocks and the RAM instance; the RAM's port signals are driven only from here.
// PARAMETERS
//  DATA_WIDTH  8                    RAM word width
//  DATA_DEPTH  128                  RAM depth in words
//  ADDR_WIDTH  $clog2(DATA_DEPTH)   address width
//  CNT_WIDTH   16                   width of per-requester grant counters
// PORTS
//  clk            in   1           single clock, all logic on posedge
//  rst_n          in   1           synchronous active-low reset
//  wr0_valid      in   1           requester 0 write request
//  wr0_addr       in   ADDR_WIDTH  requester 0 write address
//  wr0_data       in   DATA_WIDTH  requester 0 write data
//  wr0_ready      out  1           requester 0 granted this cycle
//  wr1_valid/wr1_addr/wr1_data/wr1_ready   same as wr0_*, requester 1
//  rd_valid       in   1           read request
//  rd_addr        in   ADDR_WIDTH  read address
//  rd_resp_valid  out  1           read response valid, 1 cycle after rd_valid
//  rd_resp_data   out  DATA_WIDTH  read response data
//  ram_wr_en      out  1           to RAM wr_en
//  ram_wr_addr    out  ADDR_WIDTH  to RAM wr_addr
//  ram_wr_data    out  DATA_WIDTH  to RAM data_in
//  ram_rd_addr    out  ADDR_WIDTH  to RAM rd_addr (combinational = rd_addr)
//  ram_rd_data    in   DATA_WIDTH  from RAM data_out
//  grant_cnt0     out  CNT_WIDTH   accepted writes from requester 0, saturating
//  grant_cnt1     out  CNT_WIDTH   accepted writes from requester 1, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): ram_wr_en/addr/data=0, rd_resp_valid=0, rd_resp_data=0,
//    grant_cnt0/1=0, priority pointer=requester 0. wr*_ready forced 0 while rst_n=0.
//  - Arbitration is combinational within a cycle. At most one wrX_ready is high, and only if wrX_valid=1.
//    Single valid -> that requester granted. Both valid -> the pointer's requester granted.
//  - Pointer update on a transfer (valid&ready) by requester i: pointer <= 1-i. No transfer -> pointer holds.
//    Under continuous contention, grants alternate 0,1,0,1.
//  - Write latency 1: a transfer in cycle N gives ram_wr_en=1 with the captured addr/data in cycle N+1.
//    The RAM commits the write at the end of cycle N+1. No transfer -> ram_wr_en=0; addr/data hold.
//  - Throughput: one write per cycle, no bubbles. Valid may drop without a grant; the request is not queued.
//  - Read: ram_rd_addr=rd_addr. When rd_valid=1 in cycle N: rd_resp_valid=1 in N+1, and
//    rd_resp_data = value captured at end of N. rd_valid=0 -> rd_resp_valid=0; rd_resp_data holds.
//  - Read/write collision: rd_valid in cycle N with ram_wr_en=1 and ram_wr_addr==rd_addr in N.
//    Resolved as given under CONFIGURATION.
//  - Counters: +1 per transfer of their requester; saturate at 2^CNT_WIDTH-1, never wrap.
//  - Reset mid-operation: a transfer in the reset cycle is discarded. Any pending ram_wr_en is cleared,
//    so the write is not committed. Any in-flight read response is dropped.
// CONFIGURATION
//  RAM_ARB_FWD_EN defined: on a collision, rd_resp_data = ram_wr_data (write-first / forwarded).
//  RAM_ARB_FWD_EN undefined: on a collision, rd_resp_data = ram_rd_data (old contents, read-first).
//    No forwarding logic is built.
// TESTING
//  1 Reset: hold rst_n=0 with wr0_valid=wr1_valid=1 -> both readys 0; all outputs 0; counters 0.
//  2 Contention: both valid for 4 cycles (addr 3/5) -> grants 0,1,0,1.
//    ram_wr_en=1 with addr 3,5,3,5 one cycle later; grant_cnt0=grant_cnt1=2.
//  3 Single requester: wr1 writes addr 10, data 8'hA5 -> wr1_ready same cycle; ram_wr_en next cycle.
//    rd_addr=10 two cycles later -> rd_resp_data=8'hA5.
//  4 Collision: write 8'h3C to addr 7 (old 8'h11); rd_addr=7 in the ram_wr_en cycle.
//    Response 8'h3C with RAM_ARB_FWD_EN, 8'h11 without.
//  5 Reset mid-op: rst_n=0 in the cycle after a transfer to addr 20 -> ram_wr_en=0; addr 20 unchanged.
//    Pointer=0; counters 0.
//  6 Saturation: CNT_WIDTH=2, 5 wr0 transfers -> grant_cnt0 sticks at 3.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin arbiter for the RAM write port plus a registered read path.
// Optional feature macro RAM_ARB_FWD_EN: forward the pending write to a colliding read.
module ram_access_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 128,
  parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr0_valid,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  output logic                  wr0_ready,
  input  logic                  wr1_valid,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  output logic                  wr1_ready,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_resp_valid,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [CNT_WIDTH-1:0]  grant_cnt0,
  output logic [CNT_WIDTH-1:0]  grant_cnt1
);
  logic                  ptr;
  logic                  wr_en_q;
  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_capture;
  // Grants are suppressed during reset so a transfer in the reset cycle never happens.
  assign wr0_ready = rst_n & wr0_valid & (~wr1_valid | ~ptr);
  assign wr1_ready = rst_n & wr1_valid & (~wr0_valid | ptr);
  // Gating with rst_n stops a pending write from committing and drops an in-flight response in the reset cycle.
  assign ram_wr_en     = wr_en_q & rst_n;
  assign rd_resp_valid = rd_vld_q & rst_n;
  assign ram_rd_addr   = rd_addr;
`ifdef RAM_ARB_FWD_EN
  assign rd_capture = (ram_wr_en && ram_wr_addr == rd_addr) ? ram_wr_data : ram_rd_data;
`else
  assign rd_capture = ram_rd_data;
`endif
  // Round-robin pointer, write-port capture and saturating grant counters.
  always_ff @(posedge clk)
    if (!rst_n) begin
      ptr         <= 1'b0;
      wr_en_q     <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      grant_cnt0  <= '0;
      grant_cnt1  <= '0;
    end else begin
      wr_en_q <= wr0_ready | wr1_ready;
      if (wr0_ready) begin
        ptr         <= 1'b1;
        ram_wr_addr <= wr0_addr;
        ram_wr_data <= wr0_data;
      end else if (wr1_ready) begin
        ptr         <= 1'b0;
        ram_wr_addr <= wr1_addr;
        ram_wr_data <= wr1_data;
      end
      if (wr0_ready && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_WIDTH'(1);
      if (wr1_ready && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_WIDTH'(1);
    end
  // One-cycle registered read response; data holds when no read is issued.
  always_ff @(posedge clk)
    if (!rst_n) begin
      rd_vld_q     <= 1'b0;
      rd_resp_data <= '0;
    end else begin
      rd_vld_q <= rd_valid;
      if (rd_valid) rd_resp_data <= rd_capture;
    end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: scoreboard bench for ram_access_arbiter with a behavioural RAM.
module tb_ram_access_arbiter;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic wr0_valid = 1'b0, wr1_valid = 1'b0, rd_valid = 1'b0;
  logic [AW-1:0] wr0_addr = '0, wr1_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr0_data = '0, wr1_data = '0;
  logic wr0_ready, wr1_ready, rd_resp_valid, ram_wr_en;
  logic [DW-1:0] rd_resp_data, ram_wr_data, ram_rd_data;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [CW-1:0] grant_cnt0, grant_cnt1;
  ram_access_arbiter #(.DATA_WIDTH(DW), .DATA_DEPTH(128), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr0_valid(wr0_valid), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
    .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );
  logic s_wr0_valid = 1'b0;
  logic s_wr0_ready, s_wr1_ready, s_rd_resp_valid, s_ram_wr_en;
  logic [DW-1:0] s_rd_resp_data, s_ram_wr_data;
  logic [AW-1:0] s_ram_wr_addr, s_ram_rd_addr;
  logic [1:0] s_cnt0, s_cnt1;
  ram_access_arbiter #(.DATA_WIDTH(DW), .DATA_DEPTH(128), .CNT_WIDTH(2)) sat (
    .clk(clk), .rst_n(rst_n),
    .wr0_valid(s_wr0_valid), .wr0_addr(7'd1), .wr0_data(8'h01), .wr0_ready(s_wr0_ready),
    .wr1_valid(1'b0), .wr1_addr(7'd0), .wr1_data(8'h00), .wr1_ready(s_wr1_ready),
    .rd_valid(1'b0), .rd_addr(7'd0), .rd_resp_valid(s_rd_resp_valid), .rd_resp_data(s_rd_resp_data),
    .ram_wr_en(s_ram_wr_en), .ram_wr_addr(s_ram_wr_addr), .ram_wr_data(s_ram_wr_data),
    .ram_rd_addr(s_ram_rd_addr), .ram_rd_data(8'h00),
    .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
  );
  logic [DW-1:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = '0;
  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];
  int checks = 0;
  int failures = 0;
  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin : monitor
    logic [AW+DW-1:0] we;
    logic [DW-1:0] re;
    if (ram_wr_en) begin
      if (wq.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        we = wq.pop_front();
        chk("wr_addr", 32'(ram_wr_addr), 32'(we[AW+DW-1:DW]));
        chk("wr_data", 32'(ram_wr_data), 32'(we[DW-1:0]));
      end
    end
    if (rd_resp_valid) begin
      if (rq.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        re = rq.pop_front();
        chk("rd_data", 32'(rd_resp_data), 32'(re));
      end
    end
  end
  initial begin
    wr0_valid = 1'b1;
    wr1_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ready0", 32'(wr0_ready), 0);
    chk("rst_ready1", 32'(wr1_ready), 0);
    chk("rst_wr_en", 32'(ram_wr_en), 0);
    chk("rst_wr_addr", 32'(ram_wr_addr), 0);
    chk("rst_wr_data", 32'(ram_wr_data), 0);
    chk("rst_resp_valid", 32'(rd_resp_valid), 0);
    chk("rst_resp_data", 32'(rd_resp_data), 0);
    chk("rst_cnt0", 32'(grant_cnt0), 0);
    chk("rst_cnt1", 32'(grant_cnt1), 0);
    tick();
    rst_n = 1'b1;
    wr0_addr = 7'd3; wr0_data = 8'h30;
    wr1_addr = 7'd5; wr1_data = 8'h50;
    for (int i = 0; i < 4; i++) begin
      wq.push_back((i % 2) ? {7'd5, 8'h50} : {7'd3, 8'h30});
      @(negedge clk);
      chk("cont_ready0", 32'(wr0_ready), (i % 2) ? 0 : 1);
      chk("cont_ready1", 32'(wr1_ready), (i % 2) ? 1 : 0);
      tick();
    end
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
    @(negedge clk);
    chk("cont_cnt0", 32'(grant_cnt0), 2);
    chk("cont_cnt1", 32'(grant_cnt1), 2);
    tick();
    wr1_valid = 1'b1; wr1_addr = 7'd10; wr1_data = 8'hA5;
    wq.push_back({7'd10, 8'hA5});
    @(negedge clk);
    chk("single_ready1", 32'(wr1_ready), 1);
    chk("single_ready0", 32'(wr0_ready), 0);
    tick();
    wr1_valid = 1'b0;
    @(negedge clk);
    chk("single_wr_en", 32'(ram_wr_en), 1);
    tick();
    rd_valid = 1'b1; rd_addr = 7'd10;
    rq.push_back(8'hA5);
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("single_resp_valid", 32'(rd_resp_valid), 1);
    tick();
    wr0_valid = 1'b1; wr0_addr = 7'd7; wr0_data = 8'h11;
    wq.push_back({7'd7, 8'h11});
    tick();
    wr0_valid = 1'b0;
    tick();
    wr0_valid = 1'b1; wr0_data = 8'h3C;
    wq.push_back({7'd7, 8'h3C});
    tick();
    wr0_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 7'd7;
`ifdef RAM_ARB_FWD_EN
    rq.push_back(8'h3C);
`else
    rq.push_back(8'h11);
`endif
    tick();
    rq.push_back(8'h3C);
    @(negedge clk);
    chk("coll_resp_valid", 32'(rd_resp_valid), 1);
    tick();
    rd_valid = 1'b0;
    tick();
    wr0_valid = 1'b1; wr0_addr = 7'd20; wr0_data = 8'h77;
    rd_valid = 1'b1; rd_addr = 7'd3;
    tick();
    wr0_valid = 1'b0;
    rd_valid = 1'b0;
    rst_n = 1'b0;
    wr1_valid = 1'b1; wr1_addr = 7'd9; wr1_data = 8'h99;
    @(negedge clk);
    chk("mid_rst_wr_en", 32'(ram_wr_en), 0);
    chk("mid_rst_resp_valid", 32'(rd_resp_valid), 0);
    chk("mid_rst_ready1", 32'(wr1_ready), 0);
    tick();
    rst_n = 1'b1;
    wr1_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_cnt0", 32'(grant_cnt0), 0);
    chk("mid_rst_cnt1", 32'(grant_cnt1), 0);
    chk("mid_rst_wr_addr", 32'(ram_wr_addr), 0);
    tick();
    wr0_valid = 1'b1; wr0_addr = 7'd21; wr0_data = 8'h21;
    wr1_valid = 1'b1; wr1_addr = 7'd22; wr1_data = 8'h22;
    wq.push_back({7'd21, 8'h21});
    @(negedge clk);
    chk("mid_rst_ptr_ready0", 32'(wr0_ready), 1);
    chk("mid_rst_ptr_ready1", 32'(wr1_ready), 0);
    tick();
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 7'd20;
    rq.push_back(8'h00);
    tick();
    rd_valid = 1'b0;
    s_wr0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("sat_cnt0", 32'(s_cnt0), (i < 3) ? i + 1 : 3);
    end
    s_wr0_valid = 1'b0;
    repeat (2) tick();
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
